// File: rtl/uw_frame_sync_tracker_if.sv
// rtl/uw_frame_sync_tracker_if.sv - sample stream bundle between the tracker and its neighbours
interface uw_frame_sync_tracker_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] in_q;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_sof;
  logic [1:0]               out_rot;

  // upstream source / downstream sink side
  modport master (
    output in_valid, in_i, in_q,
    input  out_valid, out_i, out_q, out_sof, out_rot
  );

  // tracker side
  modport slave (
    input  in_valid, in_i, in_q,
    output out_valid, out_i, out_q, out_sof, out_rot
  );
endinterface

// File: rtl/uw_frame_sync_tracker.sv
// rtl/uw_frame_sync_tracker.sv - streaming UW correlator with frame/phase acquisition and flywheel
module uw_frame_sync_tracker #(
  parameter int DATA_W      = 16,
  parameter int UW_LEN      = 16,
  parameter int FRAME_LEN   = 1024,
  parameter int VERIFY_HITS = 2,
  parameter int MAX_MISS    = 3,
  parameter int SCORE_W     = $clog2(UW_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  uw_frame_sync_tracker_if.slave strm,
  input  logic [2*UW_LEN-1:0]   uw_pattern,
  input  logic [SCORE_W-1:0]    threshold,
  output logic [1:0]            sync_state,
  output logic                  locked,
  output logic                  loss
);

  localparam int FILL_W = $clog2(UW_LEN + 1);
  localparam int POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int HIT_W  = $clog2(VERIFY_HITS + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(UW_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(UW_LEN - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [HIT_W-1:0]  HIT_TGT   = HIT_W'(VERIFY_HITS);
  localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(MAX_MISS);

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // Negation clamps the most negative code so a rotation never wraps sign.
  function automatic sample_t sat_neg(input sample_t x);
    return (x == MIN_NEG) ? MAX_POS : -x;
  endfunction

  // Returns {i', q'} for rotation r: r0 (i,q) r1 (q,-i) r2 (-i,-q) r3 (-q,i).
  function automatic logic [2*DATA_W-1:0] rotate(input logic [1:0] r, input sample_t i, input sample_t q);
    case (r)
      2'd0:    return {i, q};
      2'd1:    return {q, sat_neg(i)};
      2'd2:    return {sat_neg(i), sat_neg(q)};
      default: return {sat_neg(q), i};
    endcase
  endfunction

  // Hard decision {i<0, q<0}; zero is treated as non-negative.
  function automatic logic [1:0] decide(input logic [2*DATA_W-1:0] v);
    return {v[2*DATA_W-1], v[DATA_W-1]};
  endfunction

  // window and fill tracking
  sample_t             win_i [UW_LEN];
  sample_t             win_q [UW_LEN];
  logic [FILL_W-1:0]   fill;
  logic                acc_full;

  // stage 1 registers
  logic                s1_valid;
  logic [SCORE_W-1:0]  s1_score [4];
  sample_t             s1_cand_i;
  sample_t             s1_cand_q;

  // combinational scoring of the current window
  logic [SCORE_W-1:0]  score_c [4];
  logic [1:0]          best_rot;
  logic [SCORE_W-1:0]  best_score;
  logic                hit_cur;

  // FSM state and counters
  state_t              state, state_nx;
  logic [POS_W-1:0]    pos, pos_nx;
  logic [HIT_W-1:0]    hits, hits_nx;
  logic [MISS_W-1:0]   misses, misses_nx;
  logic [1:0]          rot_nx;
  logic                sof_nx;
  logic                loss_nx;
  logic [2*DATA_W-1:0] rot_out;

  // output registers
  logic                out_valid_r;
  sample_t             out_i_r;
  sample_t             out_q_r;
  logic                out_sof_r;
  logic [1:0]          out_rot_r;
  logic                loss_r;

  // Shift accepted samples into the window; flag accepts that leave it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      acc_full <= 1'b0;
      for (int k = 0; k < UW_LEN; k++) begin
        win_i[k] <= '0;
        win_q[k] <= '0;
      end
    end else begin
      acc_full <= strm.in_valid && (fill >= FILL_LAST);
      if (strm.in_valid) begin
        for (int k = 0; k < UW_LEN - 1; k++) begin
          win_i[k] <= win_i[k+1];
          win_q[k] <= win_q[k+1];
        end
        win_i[UW_LEN-1] <= strm.in_i;
        win_q[UW_LEN-1] <= strm.in_q;
        if (fill != FILL_FULL) fill <= fill + 1'b1;
      end
    end
  end

  // Correlate the window against the UW under each of the four rotations.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      score_c[r] = '0;
      for (int k = 0; k < UW_LEN; k++) begin
        if (decide(rotate(2'(r), win_i[k], win_q[k])) == uw_pattern[2*k +: 2])
          score_c[r] = score_c[r] + 1'b1;
      end
    end
  end

  // Stage 1: capture scores and the oldest window sample as output candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cand_i <= '0;
      s1_cand_q <= '0;
      for (int r = 0; r < 4; r++) s1_score[r] <= '0;
    end else begin
      s1_valid <= acc_full;
      if (acc_full) begin
        s1_cand_i <= win_i[0];
        s1_cand_q <= win_q[0];
        for (int r = 0; r < 4; r++) s1_score[r] <= score_c[r];
      end
    end
  end

  // Best rotation by score; the lowest rotation index wins a tie.
  always_comb begin
    best_rot   = 2'd0;
    best_score = s1_score[0];
    for (int r = 1; r < 4; r++) begin
      if (s1_score[r] > best_score) begin
        best_rot   = 2'(r);
        best_score = s1_score[r];
      end
    end
  end

  assign hit_cur = (s1_score[out_rot_r] >= threshold);

  // Sync FSM state register and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_SEARCH;
      pos    <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      state  <= state_nx;
      pos    <= pos_nx;
      hits   <= hits_nx;
      misses <= misses_nx;
    end
  end

  // Next-state and per-sample decisions; only off-position windows are ignored once acquired.
  always_comb begin
    state_nx  = state;
    pos_nx    = pos;
    hits_nx   = hits;
    misses_nx = misses;
    rot_nx    = out_rot_r;
    sof_nx    = 1'b0;
    loss_nx   = 1'b0;
    if (s1_valid) begin
      pos_nx = (pos == POS_LAST) ? '0 : pos + 1'b1;
      case (state)
        ST_SEARCH: begin
          if (best_score >= threshold) begin
            rot_nx    = best_rot;
            sof_nx    = 1'b1;
            pos_nx    = POS_W'(1);
            hits_nx   = HIT_W'(1);
            misses_nx = '0;
            state_nx  = (VERIFY_HITS <= 1) ? ST_LOCK : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (pos == '0) begin
            sof_nx = 1'b1;
            if (hit_cur) begin
              hits_nx = hits + 1'b1;
              if (hits + 1'b1 >= HIT_TGT) begin
                state_nx  = ST_LOCK;
                misses_nx = '0;
              end
            end else begin
              state_nx  = ST_SEARCH;
              hits_nx   = '0;
              misses_nx = '0;
            end
          end
        end
        ST_LOCK: begin
          if (pos == '0) begin
            sof_nx = 1'b1;
            if (hit_cur) begin
              misses_nx = '0;
            end else if (misses + 1'b1 >= MISS_TGT) begin
              state_nx  = ST_SEARCH;
              loss_nx   = 1'b1;
              hits_nx   = '0;
              misses_nx = '0;
            end else begin
              misses_nx = misses + 1'b1;
            end
          end
        end
        default: begin
          state_nx  = ST_SEARCH;
          hits_nx   = '0;
          misses_nx = '0;
        end
      endcase
    end
  end

  assign rot_out = rotate(rot_nx, s1_cand_i, s1_cand_q);

  // Stage 2: register the phase-corrected sample with its frame markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_i_r     <= '0;
      out_q_r     <= '0;
      out_sof_r   <= 1'b0;
      out_rot_r   <= 2'd0;
      loss_r      <= 1'b0;
    end else begin
      out_valid_r <= s1_valid;
      loss_r      <= loss_nx;
      if (s1_valid) begin
        out_i_r   <= rot_out[2*DATA_W-1:DATA_W];
        out_q_r   <= rot_out[DATA_W-1:0];
        out_sof_r <= sof_nx;
        out_rot_r <= rot_nx;
      end else begin
        out_sof_r <= 1'b0;
      end
    end
  end

  assign strm.out_valid = out_valid_r;
  assign strm.out_i     = out_i_r;
  assign strm.out_q     = out_q_r;
  assign strm.out_sof   = out_sof_r;
  assign strm.out_rot   = out_rot_r;
  assign sync_state     = state;
  assign locked         = (state == ST_LOCK);
  assign loss           = loss_r;

endmodule

// File: tb/tb_uw_frame_sync_tracker.sv
// tb/tb_uw_frame_sync_tracker.sv - randomized bench for uw_frame_sync_tracker against a frame-level model
module tb_uw_frame_sync_tracker;

  localparam int DATA_W      = 16;
  localparam int UW_LEN      = 16;
  localparam int FRAME_LEN   = 64;
  localparam int VERIFY_HITS = 2;
  localparam int MAX_MISS    = 3;
  localparam int SCORE_W     = $clog2(UW_LEN + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [2*UW_LEN-1:0]   uw_pat;
  logic [SCORE_W-1:0]    thr;
  logic [1:0]            sync_state;
  logic                  locked;
  logic                  loss;

  uw_frame_sync_tracker_if #(.DATA_W(DATA_W)) ifc ();

  uw_frame_sync_tracker #(
    .DATA_W(DATA_W), .UW_LEN(UW_LEN), .FRAME_LEN(FRAME_LEN),
    .VERIFY_HITS(VERIFY_HITS), .MAX_MISS(MAX_MISS)
  ) dut (
    .clk(clk), .rst(rst), .strm(ifc), .uw_pattern(uw_pat), .threshold(thr),
    .sync_state(sync_state), .locked(locked), .loss(loss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               sof;
    logic [1:0]         rot;
    int                 state;
    logic               lss;
    longint             due;
  } exp_t;

  exp_t   exp_q[$];
  int     hist_i[$];
  int     hist_q[$];
  longint cyc = 0;
  logic   rst_seen = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  int     cur_state = 0;

  // frame-level model: SEARCH=0 VERIFY=1 LOCK=2, anchor = sample index of the acquired UW
  int m_state = 0, m_rot = 0, m_anchor = 0, m_hits = 0, m_misses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int neg_sat(input int x);
    return (x == -32768) ? 32767 : -x;
  endfunction

  function automatic void rot_ref(input int r, input int i, input int q, output int oi, output int oq);
    case (r)
      0:       begin oi = i;          oq = q;          end
      1:       begin oi = q;          oq = neg_sat(i); end
      2:       begin oi = neg_sat(i); oq = neg_sat(q); end
      default: begin oi = neg_sat(q); oq = i;          end
    endcase
  endfunction

  function automatic int sym_of(input int i, input int q);
    return ((i < 0) ? 2 : 0) + ((q < 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    hist_i.delete();
    hist_q.delete();
    m_state = 0; m_rot = 0; m_anchor = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_accept(input int i, input int q);
    int   n, a, b, best, sym;
    int   sc[4];
    exp_t e;
    hist_i.push_back(i);
    hist_q.push_back(q);
    if (hist_i.size() < UW_LEN) return;
    n = hist_i.size() - UW_LEN;
    for (int r = 0; r < 4; r++) begin
      sc[r] = 0;
      for (int k = 0; k < UW_LEN; k++) begin
        rot_ref(r, hist_i[n+k], hist_q[n+k], a, b);
        sym = int'((uw_pat >> (2*k)) & 32'd3);
        if (sym_of(a, b) == sym) sc[r]++;
      end
    end
    best = 0;
    for (int r = 1; r < 4; r++) if (sc[r] > sc[best]) best = r;
    e.sof = 1'b0;
    e.lss = 1'b0;
    if (m_state == 0) begin
      if (sc[best] >= int'(thr)) begin
        m_rot = best; e.sof = 1'b1; m_anchor = n; m_hits = 1; m_misses = 0;
        m_state = (VERIFY_HITS == 1) ? 2 : 1;
      end
    end else if (((n - m_anchor) % FRAME_LEN) == 0) begin
      e.sof = 1'b1;
      if (m_state == 1) begin
        if (sc[m_rot] >= int'(thr)) begin
          m_hits++;
          if (m_hits >= VERIFY_HITS) begin m_state = 2; m_misses = 0; end
        end else begin
          m_state = 0; m_hits = 0; m_misses = 0;
        end
      end else begin
        if (sc[m_rot] >= int'(thr)) m_misses = 0;
        else begin
          m_misses++;
          if (m_misses >= MAX_MISS) begin
            m_state = 0; e.lss = 1'b1; m_hits = 0; m_misses = 0;
          end
        end
      end
    end
    rot_ref(m_rot, hist_i[n], hist_q[n], a, b);
    e.i     = a[15:0];
    e.q     = b[15:0];
    e.rot   = m_rot[1:0];
    e.state = m_state;
    e.due   = cyc + 3;
    exp_q.push_back(e);
  endtask

  // cycle counter and registered view of reset
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    if (rst_seen) begin
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_out_i", ifc.out_i, 0);
      chk("rst_out_q", ifc.out_q, 0);
      chk("rst_out_sof", ifc.out_sof, 0);
      chk("rst_out_rot", ifc.out_rot, 0);
      chk("rst_sync_state", sync_state, 0);
      chk("rst_locked", locked, 0);
      chk("rst_loss", loss, 0);
      cur_state = 0;
      for (int j = exp_q.size() - 1; j >= 0; j--)
        if (exp_q[j].due >= cyc && exp_q[j].due <= cyc + 2) exp_q.delete(j);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", ifc.out_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        chk("out_i", ifc.out_i, e.i);
        chk("out_q", ifc.out_q, e.q);
        chk("out_sof", ifc.out_sof, e.sof);
        chk("out_rot", ifc.out_rot, e.rot);
        chk("loss", loss, e.lss);
        cur_state = e.state;
      end else begin
        chk("loss_idle", loss, 0);
      end
      chk("sync_state", sync_state, cur_state);
      chk("locked", locked, cur_state == 2);
    end
  end

  task automatic drive(input int i, input int q, input int pct);
    while ($urandom_range(99) >= pct) begin
      ifc.in_valid = 1'b0;
      @(negedge clk);
    end
    ifc.in_valid = 1'b1;
    ifc.in_i     = 16'(i);
    ifc.in_q     = 16'(q);
    model_accept(i, q);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_rand(input int cnt, input int pct);
    logic [15:0] a, b;
    for (int s = 0; s < cnt; s++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      drive(int'($signed(a)), int'($signed(b)), pct);
    end
  endtask

  // one frame: UW (errs symbols flipped) through channel rotation chan, then random payload
  task automatic send_frame(input int errs, input int chan, input int pct);
    int          err[UW_LEN];
    int          cnt, p, mi, mq, i, q, a, b;
    logic [1:0]  sym;
    for (int k = 0; k < UW_LEN; k++) err[k] = 0;
    cnt = 0;
    while (cnt < errs && cnt < UW_LEN) begin
      p = $urandom_range(UW_LEN - 1);
      if (err[p] == 0) begin err[p] = 1; cnt++; end
    end
    for (int k = 0; k < UW_LEN; k++) begin
      sym = uw_pat[2*k +: 2];
      mi  = $urandom_range(1, 32767);
      mq  = $urandom_range(1, 32767);
      i   = sym[1] ? -mi : mi;
      q   = sym[0] ? -mq : mq;
      if (err[k] != 0) i = -i;
      rot_ref((4 - chan) % 4, i, q, a, b);
      drive(a, b, pct);
    end
    for (int d = 0; d < FRAME_LEN - UW_LEN; d++) begin
      if (d == 5)      drive(-32768, 0, pct);
      else if (d == 6) drive(0, -32768, pct);
      else             send_rand(1, pct);
    end
  endtask

  task automatic drain();
    ifc.in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int chan, pct, nf, errs;
    ifc.in_valid = 1'b0;
    ifc.in_i     = '0;
    ifc.in_q     = '0;
    uw_pat       = $urandom;
    thr          = SCORE_W'(16);
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // clean acquisition and lock, continuous input
    send_rand(10, 100);
    repeat (3) send_frame(0, 0, 100);
    // flywheel through two misses, then lose lock on the third and reacquire
    repeat (2) send_frame(16, 0, 100);
    send_frame(0, 0, 100);
    repeat (3) send_frame(16, 0, 100);
    repeat (3) send_frame(0, 0, 100);
    // reset in the middle of lock, then reacquire
    send_rand(30, 100);
    do_reset();
    send_rand(10, 100);
    repeat (3) send_frame(0, 0, 100);
    // rotated channel with bursty input
    drain();
    do_reset();
    send_rand(10, 50);
    repeat (3) send_frame(0, 1, 50);
    // threshold 14: three errors miss, two errors acquire; saturating negation under rotation 2
    drain();
    thr = SCORE_W'(14);
    do_reset();
    send_rand(10, 100);
    repeat (2) send_frame(3, 2, 100);
    repeat (3) send_frame(2, 2, 100);
    // threshold above UW_LEN never acquires; threshold 0 acquires on the first full window
    drain();
    thr = SCORE_W'(17);
    do_reset();
    send_rand(10, 100);
    repeat (2) send_frame(0, 3, 100);
    drain();
    thr = SCORE_W'(0);
    repeat (2) send_frame(0, 3, 80);
    // randomized mix of thresholds, channels, duty and UW corruption
    for (int it = 0; it < 10; it++) begin
      drain();
      thr = SCORE_W'($urandom_range(12, 16));
      if ($urandom_range(1) == 1) do_reset();
      chan = $urandom_range(3);
      pct  = $urandom_range(30, 100);
      send_rand($urandom_range(0, 40), pct);
      nf = $urandom_range(3, 5);
      for (int f = 0; f < nf; f++) begin
        errs = ($urandom_range(5) == 0) ? UW_LEN : $urandom_range(0, 4);
        send_frame(errs, chan, pct);
      end
    end
    drain();
    chk("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uw_frame_sync_tracker.md
Name: uw_frame_sync_tracker

Overview:
- Streaming successor to the BRAM-scan UW phase resolver.
- Hard-decides incoming QPSK samples into a sliding UW_LEN window and correlates it against the unique word for all four 90° rotations.
- Acquires frame and phase, verifies over consecutive frames, then flywheels with miss tolerance.
- Emits phase-corrected samples with a start-of-frame flag for downstream demap/deframe.

Parameters:
DATA_W, 16, signed I/Q sample width
UW_LEN, 16, UW length in symbols (>=2)
FRAME_LEN, 1024, frame period in samples incl. UW (>=UW_LEN)
VERIFY_HITS, 2, consecutive UW hits (incl. acquisition) to reach LOCK
MAX_MISS, 3, consecutive UW misses in LOCK that drop lock
SCORE_W, clog2(UW_LEN+1), score/threshold width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample strobe; no backpressure
in_i  in  DATA_W  signed I
in_q  in  DATA_W  signed Q
uw_pattern  in  2*UW_LEN  bits [2k+1:2k] = UW symbol k; k=0 transmitted first
threshold  in  SCORE_W  minimum matching symbols for a hit
out_valid  out  1  corrected sample strobe
out_i  out  DATA_W  corrected I
out_q  out  DATA_W  corrected Q
out_sof  out  1  with out_valid: sample is UW symbol 0
out_rot  out  2  rotation in use
sync_state  out  2  0 SEARCH, 1 VERIFY, 2 LOCK
locked  out  1  sync_state==LOCK
loss  out  1  one-cycle pulse when LOCK drops to SEARCH

Behaviour:
- Reset: all outputs 0; window fill=0; pipeline cleared; state SEARCH. Reset mid-stream discards all buffered samples.
- Rotation r applied to (i,q): r0 (i,q); r1 (q,-i); r2 (-i,-q); r3 (-q,i).
- Negation saturates: -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
- Hard decision of a corrected sample: symbol = {i<0, q<0}; zero counts as non-negative.
- Window W[0..UW_LEN-1], W[0] oldest. Each accepted input shifts W and writes W[UW_LEN-1]. Fill counter saturates at UW_LEN. Idle cycles hold everything.
- Stage 1, edge after an accept with fill==UW_LEN:
  - score[r] = count of k where decision(rot_r(W[k])) == pattern symbol k, for r = 0..3.
  - Register score[0..3] and candidate = W[0].
- best_rot = argmax score; lowest r wins ties.
- Stage 2, next edge: FSM update and output register. out_valid=1 with rot_{out_rot}(candidate). out_rot and out_sof take their newly decided values for this sample.
- Throughput and latency:
  - One output per accept once the window is full.
  - Sample n appears 2 cycles after accept of sample n+UW_LEN-1.
  - First UW_LEN-1 accepts produce no output.
- pos counter (clog2(FRAME_LEN) bits) counts stage-2 outputs modulo FRAME_LEN; wraps FRAME_LEN-1 -> 0.
- SEARCH:
  - If score[best_rot] >= threshold: out_rot<=best_rot, out_sof=1, pos<=1, hits<=1, misses<=0.
  - Go to LOCK if VERIFY_HITS==1, else VERIFY.
  - First qualifying window wins.
- VERIFY/LOCK, only when pos==0 (expected UW):
  - out_sof=1 regardless of hit/miss.
  - Evaluate score[out_rot] >= threshold; out_rot is frozen.
  - VERIFY hit: hits++; at VERIFY_HITS go to LOCK.
  - VERIFY miss: go to SEARCH; out_sof still 1 this sample.
  - LOCK hit: misses<=0.
  - LOCK miss: misses++. At MAX_MISS go to SEARCH with loss=1 for one cycle. The new state is visible with this output.
  - Off-position windows are ignored, even high-scoring ones.
- Entering SEARCH clears hits/misses. The window is not flushed, so reacquisition can occur on the next output.
- threshold==0: first full window acquires. threshold>UW_LEN: never acquires; outputs still stream with out_rot=0.

Test Plan:
1. UW_LEN=16, FRAME_LEN=64, threshold=16, random data, UW at samples 10,74,138, no rotation, in_valid continuous -> out_sof on samples 10/74/138, out_rot=0, VERIFY after 10, locked=1 on sample 74's output, output sample n at 2 cycles after accept n+15.
2. Same stream rotated: transmit (i,q) sent as (-q,i) -> acquisition with out_rot=1; out_i/out_q equal original transmitted values bit-exact.
3. Locked, UW fully corrupted in 2 consecutive frames -> locked stays 1, out_sof every 64 outputs. Corrupt 3 consecutive frames -> loss pulse and locked=0 on the third expected-UW output; next clean UW reacquires.
4. Same data as 1 with in_valid random 50% -> identical out_* sequence. out_valid count = accepts-15. No output on idle-only cycles.
5. threshold=14: UW with 2 symbol errors acquires; with 3 errors it does not. Input (-32768,0) with out_rot=2 -> out (32767,0).
6. rst asserted for one cycle mid-LOCK -> all outputs 0 next cycle, state SEARCH. No out_valid until 16 new accepts; reacquire on next UW.
